// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL bring-up sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pll_seq_pkg;

  // Encodings are visible on the debug state port, so the values are fixed.
  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  localparam int RETRY_W = 4;

  localparam int DEF_RESET_CYCLES  = 16;
  localparam int DEF_LOCK_TIMEOUT  = 12000;  // 1 ms at 12 MHz
  localparam int DEF_STABLE_CYCLES = 1200;
  localparam int DEF_MAX_RETRIES   = 7;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for slow or level signals crossing into clk_i.
// Latency: 2 clk_i edges from d_i to q_o.
// Backpressure: none; both stages reset to 0.
// Ports: clk_i destination clock, rst_ni async active-low reset,
//        d_i asynchronous input, q_o synchronized output.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_sequencer.sv
// Brings up the PLL, waits for stable lock, then releases the core reset; retries on failure, parks in FAULT.
// Latency: locked_in -> FSM 2 edges; every output is registered and changes on the same edge as state.
// Backpressure: none; restart is a single-cycle request that overrides all other transitions.
// Ports: clock/reset_n reference clock and async active-low reset; locked_in PLL LOCK (async);
//        restart restart request; pll_resetb PLL RESETB; core_reset_n core-domain reset;
//        ready/fail RUN/FAULT flags; lock_lost sticky lock-drop flag; retry_count; state (debug).
module pll_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               locked_in,
  input  logic               restart,
  output logic               pll_resetb,
  output logic               core_reset_n,
  output logic               ready,
  output logic               fail,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count,
  output logic [2:0]         state
);

  localparam int MAX_A   = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int CNT_MAX = (MAX_A > RESET_CYCLES) ? MAX_A : RESET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RTY_MAX  = RETRY_W'(MAX_RETRIES);

  logic lock_s;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .d_i    (locked_in),
    .q_o    (lock_s)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               lost_q, lost_d;
  logic               pll_resetb_q, pll_resetb_d;
  logic               core_rst_n_q, core_rst_n_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TO_LAST) begin
          // The last tolerated attempt has just failed: give up rather than wrap the count.
          if (retry_q == RTY_MAX) begin
            state_d = ST_FAULT;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_RESET_PLL;
          end
        end
      end
      ST_STABLE: begin
        // A dropout here is treated as "not locked yet", not as a failed attempt.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_RESET_PLL;
          lost_d  = 1'b1;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_RESET_PLL;
      end
    endcase

    if (restart) begin
      state_d = ST_RESET_PLL;
      retry_d = '0;
      lost_d  = 1'b0;
    end

    // Restart re-enters RESET_PLL even from RESET_PLL, so it also rewinds the count.
    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == ST_RESET_PLL) || (state_q == ST_WAIT_LOCK) ||
                 (state_q == ST_STABLE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs are decoded from the next state so they flip on the same edge as state_q.
  always_comb begin
    pll_resetb_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) || (state_d == ST_RUN);
    core_rst_n_d = (state_d == ST_RUN);
    ready_d      = (state_d == ST_RUN);
    fail_d       = (state_d == ST_FAULT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RESET_PLL;
      cnt_q        <= '0;
      retry_q      <= '0;
      lost_q       <= 1'b0;
      pll_resetb_q <= 1'b0;
      core_rst_n_q <= 1'b0;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      lost_q       <= lost_d;
      pll_resetb_q <= pll_resetb_d;
      core_rst_n_q <= core_rst_n_d;
      ready_q      <= ready_d;
      fail_q       <= fail_d;
    end
  end

  assign pll_resetb   = pll_resetb_q;
  assign core_reset_n = core_rst_n_q;
  assign ready        = ready_q;
  assign fail         = fail_q;
  assign lock_lost    = lost_q;
  assign retry_count  = retry_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pll_sequencer.sv
// Directed bench for pll_sequencer with short timing parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_pll_sequencer;

  logic       clock;
  logic       reset_n;
  logic       locked_in;
  logic       restart;
  logic       pll_resetb;
  logic       core_reset_n;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [3:0] retry_count;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  pll_sequencer #(
    .RESET_CYCLES  (4),
    .LOCK_TIMEOUT  (20),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .locked_in    (locked_in),
    .restart      (restart),
    .pll_resetb   (pll_resetb),
    .core_reset_n (core_reset_n),
    .ready        (ready),
    .fail         (fail),
    .lock_lost    (lock_lost),
    .retry_count  (retry_count),
    .state        (state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] st, input logic prb,
                          input logic crn, input logic rdy, input logic fl,
                          input logic ll, input logic [3:0] rc);
    chk({tag, ".state"},        {5'd0, state},        {5'd0, st});
    chk({tag, ".pll_resetb"},   {7'd0, pll_resetb},   {7'd0, prb});
    chk({tag, ".core_reset_n"}, {7'd0, core_reset_n}, {7'd0, crn});
    chk({tag, ".ready"},        {7'd0, ready},        {7'd0, rdy});
    chk({tag, ".fail"},         {7'd0, fail},         {7'd0, fl});
    chk({tag, ".lock_lost"},    {7'd0, lock_lost},    {7'd0, ll});
    chk({tag, ".retry_count"},  {4'd0, retry_count},  {4'd0, rc});
  endtask

  initial begin
    reset_n   = 1'b0;
    locked_in = 1'b1;
    restart   = 1'b0;

    // Reset state while reset_n is held low across edges.
    edges(3);
    chk_outs("rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Fast bring-up: release between edges; edge 1 is the next rising edge.
    #2;
    reset_n = 1'b1;
    edges(3);
    chk_outs("fast.e3", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    edges(1);
    chk_outs("fast.e4", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    edges(1);
    chk_outs("fast.e5", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    edges(7);
    chk_outs("fast.e12", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    edges(1);
    chk_outs("fast.e13", 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

    // Lock loss in RUN: core reset falls on the 3rd edge after the drop.
    locked_in = 1'b0;
    edges(2);
    chk_outs("loss.a2", 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    edges(1);
    chk_outs("loss.a3", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    locked_in = 1'b1;
    edges(3);
    chk_outs("loss.a6", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    edges(1);
    chk_outs("loss.a7", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    edges(1);
    chk_outs("loss.a8", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);

    // One-cycle lock glitch two cycles into STABLE.
    edges(2);
    locked_in = 1'b0;
    edges(1);
    locked_in = 1'b1;
    edges(1);
    chk_outs("glitch.g2", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    edges(1);
    chk_outs("glitch.g3", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    edges(1);
    chk_outs("glitch.g4", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    edges(7);
    chk_outs("glitch.g11", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    edges(1);
    chk_outs("glitch.g12", 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0);

    // Restart from RUN with lock gone, then let every attempt time out.
    locked_in = 1'b0;
    restart   = 1'b1;
    edges(1);
    restart = 1'b0;
    chk_outs("to.r0", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    edges(3);
    chk_outs("to.r3", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    edges(1);
    chk_outs("to.r4", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    edges(19);
    chk_outs("to.r23", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    edges(1);
    chk_outs("to.r24", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    edges(4);
    chk_outs("to.r28", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    edges(20);
    chk_outs("to.r48", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
    edges(23);
    chk_outs("to.r71", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
    edges(1);
    chk_outs("to.r72", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);

    // FAULT holds regardless of lock returning.
    locked_in = 1'b1;
    edges(100);
    chk_outs("fault.hold", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);

    // Restart from FAULT; lock already synchronized, so RUN 13 edges later.
    restart = 1'b1;
    edges(1);
    restart = 1'b0;
    chk_outs("rs.s0", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    edges(4);
    chk_outs("rs.s4", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    edges(8);
    chk_outs("rs.s12", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    edges(1);
    chk_outs("rs.s13", 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

    // Async reset mid-cycle in RUN: outputs clear before the next edge.
    #2;
    reset_n = 1'b0;
    #1;
    chk_outs("arst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    edges(2);
    chk_outs("arst.hold", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    reset_n = 1'b1;
    edges(4);
    chk_outs("arst.rel", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_sequencer.md
# pll_sequencer

Bring-up and supervision controller for the iCE40 PLL. It runs on the 12 MHz reference clock, drives the PLL's `RESETB`, and watches its `LOCK` output. It releases the core-domain reset only after lock has been stable for a programmable time. On lock loss or lock timeout it retries automatically, and after a bounded number of failed attempts it parks in a fault state.

## Interface
Parameters:
- `RESET_CYCLES`, default 16: cycles `pll_resetb` is held low per attempt (≥2).
- `LOCK_TIMEOUT`, default 12000: cycles allowed in WAIT_LOCK before the attempt fails (1 ms at 12 MHz).
- `STABLE_CYCLES`, default 1200: consecutive synchronized-lock cycles required before RUN (≥1).
- `MAX_RETRIES`, default 7: failed attempts tolerated before FAULT (≤15).

Ports:
- `clock`, in, 1: reference clock. One clock for the whole block.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `locked_in`, in, 1: PLL `LOCK`. Asynchronous to `clock`.
- `restart`, in, 1: single-cycle request to restart the sequence.
- `pll_resetb`, out, 1: to PLL `RESETB`. 0 holds the PLL in reset.
- `core_reset_n`, out, 1: active-low reset for the PLL-clocked domain. The consumer re-synchronizes it.
- `ready`, out, 1: high only in RUN.
- `fail`, out, 1: high only in FAULT.
- `lock_lost`, out, 1: sticky. Set when lock drops in RUN; cleared by `restart` or reset.
- `retry_count`, out, 4: failed attempts since the last RUN entry or restart.
- `state`, out, 3: current state encoding, for debug.

## Operation
- `locked_in` passes through a 2-flop synchronizer to give `lock_s`. Both flops reset to 0.
- One cycle counter (width sized for the maximum of `LOCK_TIMEOUT`, `STABLE_CYCLES`, `RESET_CYCLES`) is cleared on every state change.
- States and transitions:
  - **RESET_PLL** (0): `pll_resetb`=0. Goes to WAIT_LOCK once the counter reaches `RESET_CYCLES`-1.
  - **WAIT_LOCK** (1): `pll_resetb`=1.
    - `lock_s`=1 → STABLE.
    - Counter reaches `LOCK_TIMEOUT`-1 while `lock_s`=0 → FAULT if `retry_count`==`MAX_RETRIES`; otherwise increment `retry_count` and go to RESET_PLL.
  - **STABLE** (2): `pll_resetb`=1.
    - `lock_s`=0 → WAIT_LOCK. Counter clears and the timeout restarts; `retry_count` is unchanged.
    - Counter reaches `STABLE_CYCLES`-1 with `lock_s`=1 → RUN. `retry_count` clears.
  - **RUN** (3): `core_reset_n`=1, `ready`=1.
    - `lock_s`=0 → RESET_PLL and set `lock_lost`. This is not counted as a retry.
  - **FAULT** (4): `pll_resetb`=0, `fail`=1. Leaves only on `restart`.
- `restart` in any state goes to RESET_PLL, clears `retry_count` and `lock_lost`, and overrides every other transition in that cycle.
- `core_reset_n`=0 in every state except RUN.
- `retry_count` never exceeds `MAX_RETRIES`.
- Unused state encodings (5–7) go to RESET_PLL.

## Timing
- Reset values:
  - `state`=RESET_PLL, counter=0, `retry_count`=0.
  - `pll_resetb`=0, `core_reset_n`=0, `ready`=0, `fail`=0, `lock_lost`=0.
- All outputs are registered and decoded from the next state, so they change on the same edge as `state`. There is no combinational path from any input to any output.
- `locked_in` reaches `lock_s` in 2 cycles.
- Lock loss in RUN: `core_reset_n` falls 3 edges after `locked_in` falls (2 synchronizer edges + 1 transition edge).
- Each attempt keeps `pll_resetb` low for exactly `RESET_CYCLES` cycles.
- Fast path with `lock_s` already high: `core_reset_n` rises on edge `RESET_CYCLES`+1+`STABLE_CYCLES` after reset release. This is `RESET_CYCLES` cycles in RESET_PLL, 1 in WAIT_LOCK, and `STABLE_CYCLES` in STABLE.
- `reset_n` asserted mid-operation forces all reset values immediately, without waiting for a clock edge.

## Structure
- Package `pll_seq_pkg` holds:
  - the state enum (RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4);
  - the `retry_count` width constant;
  - default parameter constants.
- Sub-module `sync_2ff`: a generic 2-flop synchronizer with asynchronous active-low reset, reusable elsewhere. `pll_sequencer` instantiates it for `locked_in`.

## Test plan
Test parameters: `RESET_CYCLES`=4, `LOCK_TIMEOUT`=20, `STABLE_CYCLES`=8, `MAX_RETRIES`=2.

- **Fast bring-up:** `locked_in`=1 constantly, release `reset_n` → `pll_resetb` rises on edge 4; `core_reset_n` and `ready` rise on edge 13; `retry_count`=0.
- **Lock glitch in STABLE:** deassert `locked_in` for 1 cycle mid-STABLE → return to WAIT_LOCK. `core_reset_n` rises 8 cycles after lock re-settles; `retry_count` unchanged.
- **Timeouts to FAULT:** `locked_in`=0 always → three attempts of 4 low + 20 high `pll_resetb` cycles; `retry_count` goes 0→1→2; then FAULT with `fail`=1 and `pll_resetb`=0. Hold 100 cycles in FAULT: no change.
- **Lock loss in RUN:** in RUN, drop `locked_in` → `core_reset_n`=0 and `ready`=0 on the 3rd edge after the drop; `lock_lost`=1; `pll_resetb` low for 4 cycles; `retry_count` stays 0.
- **Restart from FAULT:** one-cycle `restart` in FAULT → next state RESET_PLL, `retry_count`=0, `lock_lost`=0, `fail`=0. With `locked_in`=1, RUN follows 13 cycles later.
- **Async reset in RUN:** pulse `reset_n` low between edges → all outputs take their reset values immediately, before the next edge.
